// File: rtl/rtc_pkg.sv
// Purpose: shared calendar constants, time record type and month-length helper for the RTC.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Consumers: rtc_time_counter (cascade + set validation) and the BCD display path.
package rtc_pkg;

  // One calendar/time snapshot; all fields binary.
  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
    logic [7:0] days;
    logic [7:0] months;
    logic [7:0] years;
  } rtc_time_t;

  // Field limits.
  localparam logic [7:0] SEC_MAX   = 8'd59;
  localparam logic [7:0] MIN_MAX   = 8'd59;
  localparam logic [7:0] HOUR_MAX  = 8'd23;
  localparam logic [7:0] MONTH_MAX = 8'd12;
  localparam logic [7:0] YEAR_MAX  = 8'd99;
  localparam logic [7:0] DAY_MIN   = 8'd1;
  localparam logic [7:0] MONTH_MIN = 8'd1;

  // Reset date: 00:00:00 01/01/2000.
  localparam rtc_time_t RST_TIME = '{hour: 8'd0, min: 8'd0, sec: 8'd0,
                                     days: 8'd1, months: 8'd1, years: 8'd0};

  // Month length. Years are 2000-2099, so every multiple of four is a leap year.
  // Out-of-range months return 31; callers validate the month separately.
  function automatic logic [7:0] days_in_month(input logic [7:0] month,
                                               input logic [7:0] year);
    logic [7:0] dim;
    case (month)
      8'd4, 8'd6, 8'd9, 8'd11: dim = 8'd30;
      8'd2:                    dim = ((year & 8'd3) == 8'd0) ? 8'd29 : 8'd28;
      default:                 dim = 8'd31;
    endcase
    return dim;
  endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Purpose: divides clk down to a one-cycle tick every TICK_DIV cycles.
// Latency: tick is combinational from the counter; first tick TICK_DIV cycles after rst/clr.
// Backpressure: none; free-running.
//
// Ports: clk, rst (sync, active-high), clr (restart count at 0 on next edge),
//        tick (high during the cycle the counter sits at TICK_DIV-1).
module rtc_prescaler #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rtc_time_counter.sv
// Purpose: binary real-time clock/calendar (2000-2099) with validated one-shot load.
// Latency: all outputs registered; fields, sec_tick and set_err update one edge after tick/set.
// Backpressure: none; every set_valid cycle is evaluated, no stall.
//
// Ports: clk, rst (sync, active-high), set_valid + set_{sec,min,hour,days,months,years} load request,
//        sec/min/hour/days/months/years binary time, sec_tick (seconds advanced), set_err (set rejected).
module rtc_time_counter
  import rtc_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_valid,
  input  logic [7:0] set_sec,
  input  logic [7:0] set_min,
  input  logic [7:0] set_hour,
  input  logic [7:0] set_days,
  input  logic [7:0] set_months,
  input  logic [7:0] set_years,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hour,
  output logic [7:0] days,
  output logic [7:0] months,
  output logic [7:0] years,
  output logic       sec_tick,
  output logic       set_err
);

  rtc_time_t time_q, time_d, set_t;
  logic      sec_tick_q, sec_tick_d;
  logic      set_err_q, set_err_d;
  logic      tick, set_ok, set_acc;
  logic      wrap_sec, wrap_min, wrap_hour, wrap_day, wrap_mon, wrap_year;
  logic      c_sec, c_min, c_hour, c_day, c_mon, c_year;

  assign set_t = '{hour: set_hour, min: set_min, sec: set_sec,
                   days: set_days, months: set_months, years: set_years};

  assign set_ok = (set_sec <= SEC_MAX) && (set_min <= MIN_MAX) && (set_hour <= HOUR_MAX) &&
                  (set_months >= MONTH_MIN) && (set_months <= MONTH_MAX) &&
                  (set_years <= YEAR_MAX) && (set_days >= DAY_MIN) &&
                  (set_days <= days_in_month(set_months, set_years));
  assign set_acc = set_valid && set_ok;

  // An accepted set restarts the second, so a tick in the same cycle is dropped.
  rtc_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (set_acc),
    .tick (tick)
  );

  assign wrap_sec  = (time_q.sec    == SEC_MAX);
  assign wrap_min  = (time_q.min    == MIN_MAX);
  assign wrap_hour = (time_q.hour   == HOUR_MAX);
  assign wrap_day  = (time_q.days   >= days_in_month(time_q.months, time_q.years));
  assign wrap_mon  = (time_q.months == MONTH_MAX);
  assign wrap_year = (time_q.years  == YEAR_MAX);

  // Carry chain: c_x means field x advances this cycle; the whole ripple settles in one cycle.
  assign c_sec  = tick && !set_acc;
  assign c_min  = c_sec  && wrap_sec;
  assign c_hour = c_min  && wrap_min;
  assign c_day  = c_hour && wrap_hour;
  assign c_mon  = c_day  && wrap_day;
  assign c_year = c_mon  && wrap_mon;

  always_comb begin
    time_d = time_q;
    if (set_acc) begin
      time_d = set_t;
    end else begin
      if (c_sec)  time_d.sec    = wrap_sec  ? 8'd0      : time_q.sec    + 8'd1;
      if (c_min)  time_d.min    = wrap_min  ? 8'd0      : time_q.min    + 8'd1;
      if (c_hour) time_d.hour   = wrap_hour ? 8'd0      : time_q.hour   + 8'd1;
      if (c_day)  time_d.days   = wrap_day  ? DAY_MIN   : time_q.days   + 8'd1;
      if (c_mon)  time_d.months = wrap_mon  ? MONTH_MIN : time_q.months + 8'd1;
      if (c_year) time_d.years  = wrap_year ? 8'd0      : time_q.years  + 8'd1;
    end
  end

  assign sec_tick_d = c_sec;
  assign set_err_d  = set_valid && !set_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      time_q     <= RST_TIME;
      sec_tick_q <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      time_q     <= time_d;
      sec_tick_q <= sec_tick_d;
      set_err_q  <= set_err_d;
    end
  end

  assign sec      = time_q.sec;
  assign min      = time_q.min;
  assign hour     = time_q.hour;
  assign days     = time_q.days;
  assign months   = time_q.months;
  assign years    = time_q.years;
  assign sec_tick = sec_tick_q;
  assign set_err  = set_err_q;

endmodule

// File: tb/tb_rtc_time_counter.sv
// Purpose: directed, table-driven check of rtc_time_counter with TICK_DIV=4.
// Latency: n/a (bench).
// Backpressure: n/a.
module tb_rtc_time_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       set_valid;
  logic [7:0] set_sec, set_min, set_hour, set_days, set_months, set_years;
  logic [7:0] sec, min, hour, days, months, years;
  logic       sec_tick, set_err;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  rtc_time_counter #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .set_valid  (set_valid),
    .set_sec    (set_sec),
    .set_min    (set_min),
    .set_hour   (set_hour),
    .set_days   (set_days),
    .set_months (set_months),
    .set_years  (set_years),
    .sec        (sec),
    .min        (min),
    .hour       (hour),
    .days       (days),
    .months     (months),
    .years      (years),
    .sec_tick   (sec_tick),
    .set_err    (set_err)
  );

  // {hour,min,sec,days,months,years}
  function automatic logic [47:0] tm(input int h, input int m, input int s,
                                     input int d, input int mo, input int y);
    return {8'(h), 8'(m), 8'(s), 8'(d), 8'(mo), 8'(y)};
  endfunction

  function automatic logic [47:0] dut_time();
    return {hour, min, sec, days, months, years};
  endfunction

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_set(input logic v, input logic [47:0] t);
    set_valid = v;
    {set_hour, set_min, set_sec, set_days, set_months, set_years} = t;
  endtask

  typedef struct {
    bit          sv;      // set_valid in the set cycle
    logic [47:0] st;      // set fields
    int          run;     // idle cycles after the set cycle
    logic [47:0] et;      // expected time after the run
    bit          etick0;  // expected sec_tick after the set cycle
    bit          eerr;    // expected set_err after the set cycle
    int          eticks;  // expected sec_tick count during the run
  } vec_t;

  vec_t v[21];

  initial begin
    int ticks;
    int cnt;

    // Prescaler phase noted per row; it carries over between rows.
    v[0]  = '{1'b1, tm(23,59,59,31,12,99), 4, tm(0,0,0,1,1,0),     1'b0, 1'b0, 1};
    v[1]  = '{1'b1, tm(23,59,59,28,2,24),  4, tm(0,0,0,29,2,24),   1'b0, 1'b0, 1};
    v[2]  = '{1'b1, tm(23,59,59,28,2,23),  4, tm(0,0,0,1,3,23),    1'b0, 1'b0, 1};
    v[3]  = '{1'b1, tm(23,59,59,30,4,10),  4, tm(0,0,0,1,5,10),    1'b0, 1'b0, 1};
    v[4]  = '{1'b1, tm(0,0,0,31,4,10),     2, tm(0,0,0,1,5,10),    1'b0, 1'b1, 0}; // phase 1..3
    v[5]  = '{1'b1, tm(0,0,60,1,1,0),      4, tm(0,0,2,1,5,10),    1'b1, 1'b1, 1}; // reject on tick
    v[6]  = '{1'b1, tm(24,0,0,1,1,0),      3, tm(0,0,3,1,5,10),    1'b0, 1'b1, 1};
    v[7]  = '{1'b1, tm(0,0,0,1,13,0),      0, tm(0,0,3,1,5,10),    1'b0, 1'b1, 0}; // phase 1
    v[8]  = '{1'b1, tm(0,0,0,29,2,23),     0, tm(0,0,3,1,5,10),    1'b0, 1'b1, 0}; // phase 2
    v[9]  = '{1'b1, tm(0,60,0,1,1,0),      0, tm(0,0,3,1,5,10),    1'b0, 1'b1, 0}; // phase 3
    v[10] = '{1'b1, tm(1,2,3,15,6,50),     3, tm(1,2,3,15,6,50),   1'b0, 1'b0, 0}; // accept on tick
    v[11] = '{1'b0, tm(0,0,0,0,0,0),       0, tm(1,2,4,15,6,50),   1'b1, 1'b0, 0};
    v[12] = '{1'b1, tm(10,20,30,29,2,24),  0, tm(10,20,30,29,2,24), 1'b0, 1'b0, 0};
    v[13] = '{1'b1, tm(0,0,0,0,1,0),       0, tm(10,20,30,29,2,24), 1'b0, 1'b1, 0};
    v[14] = '{1'b1, tm(0,0,0,1,1,100),     0, tm(10,20,30,29,2,24), 1'b0, 1'b1, 0};
    v[15] = '{1'b1, tm(12,59,59,31,1,1),   4, tm(13,0,0,31,1,1),   1'b0, 1'b0, 1};
    v[16] = '{1'b1, tm(23,59,59,31,1,5),   4, tm(0,0,0,1,2,5),     1'b0, 1'b0, 1};
    v[17] = '{1'b1, tm(23,59,59,30,6,7),   4, tm(0,0,0,1,7,7),     1'b0, 1'b0, 1};
    v[18] = '{1'b1, tm(22,59,59,29,2,0),   4, tm(23,0,0,29,2,0),   1'b0, 1'b0, 1};
    v[19] = '{1'b1, tm(23,59,59,29,2,0),   4, tm(0,0,0,1,3,0),     1'b0, 1'b0, 1};
    v[20] = '{1'b1, tm(0,0,58,1,1,0),      8, tm(0,1,0,1,1,0),     1'b0, 1'b0, 2};

    rst = 1'b1;
    drive_set(1'b0, '0);

    // Reset state, then free-running ticks on cycles 4, 8, 12.
    repeat (3) @(negedge clk);
    chk("reset_time", dut_time(), tm(0,0,0,1,1,0));
    chk("reset_sec_tick", 48'(sec_tick), 48'd0);
    chk("reset_set_err", 48'(set_err), 48'd0);
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk($sformatf("run_tick_c%0d", c), 48'(sec_tick), 48'((c % 4) == 0));
      if ((c % 4) == 0) chk($sformatf("run_sec_c%0d", c), 48'(sec), 48'(c / 4));
    end

    // Table of set requests followed by idle runs.
    for (int i = 0; i < 21; i++) begin
      drive_set(v[i].sv, v[i].st);
      @(negedge clk);
      chk($sformatf("v%0d_set_tick", i), 48'(sec_tick), 48'(v[i].etick0));
      chk($sformatf("v%0d_set_err", i), 48'(set_err), 48'(v[i].eerr));
      drive_set(1'b0, '0);
      ticks = 0;
      for (int k = 0; k < v[i].run; k++) begin
        @(negedge clk);
        if (sec_tick) ticks++;
      end
      chk($sformatf("v%0d_time", i), dut_time(), v[i].et);
      chk($sformatf("v%0d_ticks", i), 48'(ticks), 48'(v[i].eticks));
    end

    // Reset mid-second beats a coincident valid set; prescaler restarts.
    drive_set(1'b1, tm(12,34,56,1,1,0));
    @(negedge clk);
    drive_set(1'b0, '0);
    repeat (2) @(negedge clk);
    chk("pre_rst_time", dut_time(), tm(12,34,56,1,1,0));
    rst = 1'b1;
    drive_set(1'b1, tm(23,59,59,31,12,99));
    @(negedge clk);
    chk("mid_rst_time", dut_time(), tm(0,0,0,1,1,0));
    chk("mid_rst_tick", 48'(sec_tick), 48'd0);
    chk("mid_rst_err", 48'(set_err), 48'd0);
    rst = 1'b0;
    drive_set(1'b0, '0);
    cnt = 0;
    while (cnt < 10) begin
      @(negedge clk);
      cnt++;
      if (sec_tick) break;
    end
    chk("post_rst_tick_delay", 48'(cnt), 48'd4);
    chk("post_rst_sec", 48'(sec), 48'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/rtc_time_counter.md
RTC_TIME_COUNTER -- requirements
Module: rtc_time_counter

Interface
REQ-001 Parameter TICK_DIV, default 100000000, clk cycles per second; legal range 2 to 2^27.
REQ-002 clk  in  1  system clock; all logic SHALL be on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 set_valid  in  1  one-cycle request to load the set_* fields.
REQ-005 set_sec, set_min, set_hour, set_days, set_months, set_years  in  8 each  binary load values.
REQ-006 sec, min, hour  out  8 each  binary time: sec 0-59, min 0-59, hour 0-23.
REQ-007 days, months, years  out  8 each  binary date: days 1-31, months 1-12, years 0-99 (2000-2099).
REQ-008 sec_tick  out  1  one-cycle pulse in the cycle the seconds field advances.
REQ-009 set_err  out  1  one-cycle pulse when set_valid carries an out-of-range field.
REQ-010 All outputs SHALL be registered, feeding the downstream binary-to-BCD stage directly.

Function
REQ-011 Prescaler: counts 0 to TICK_DIV-1 and wraps; the wrap cycle is the tick; the tick period SHALL be exactly TICK_DIV cycles.
REQ-012 On a tick, sec SHALL increment; 59 -> 0 with carry to min.
REQ-013 min carry: 59 -> 0 with carry to hour; hour carry: 23 -> 0 with carry to days.
REQ-014 days carry: days == days_in_month(months, years) -> 1, carry to months; else increment.
REQ-015 days_in_month: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; February 29 when years[1:0] == 0, else 28.
REQ-016 months carry: 12 -> 1, carry to years; years 99 -> 0 (wrap, no flag).
REQ-017 All carries SHALL resolve in the tick cycle; the outputs from 23:59:59 31/12/99 are 00:00:00 01/01/00 one clock after the tick.
REQ-018 sec_tick SHALL assert registered, in the same cycle the new sec value appears.
REQ-019 Set validation: accept only when sec<=59, min<=59, hour<=23, 1<=months<=12, years<=99, 1<=days<=days_in_month(set_months, set_years).
REQ-020 Accepted set: all six fields SHALL load on the next edge, the prescaler SHALL clear to 0, no sec_tick that cycle.
REQ-021 Rejected set: no field or prescaler change; set_err pulses for one cycle on the next edge.
REQ-022 set_valid coincident with a tick: an accepted set SHALL win and the tick is discarded; a rejected set SHALL let the tick proceed normally.
REQ-023 Back-to-back set_valid cycles SHALL each be evaluated independently; the last accepted set holds.

Reset
REQ-024 rst SHALL have priority over set_valid and tick.
REQ-025 Reset values: sec=0, min=0, hour=0, days=1, months=1, years=0, prescaler=0, sec_tick=0, set_err=0.
REQ-026 Reset asserted mid-second SHALL restart the prescaler; first tick comes TICK_DIV cycles after rst deasserts.

Structure
REQ-027 Shared package rtc_pkg SHALL hold the field limit constants (59, 23, 12, 99), the reset date constants and the days_in_month function, for reuse by the set-validation logic and the BCD display path.
REQ-028 One sub-module, rtc_prescaler (TICK_DIV, clk, rst, clr -> tick), SHALL hold the divider; the calendar cascade SHALL stay in rtc_time_counter.
REQ-029 Prescaler width SHALL be $clog2(TICK_DIV); no other arithmetic wider than 8 bits.

Verification (TICK_DIV=4)
REQ-030 Release rst and run 12 cycles -> sec_tick on cycles 4, 8, 12; sec reads 1, 2, 3.
REQ-031 Set 23:59:59 31/12/99, run 4 cycles -> 00:00:00 01/01/00 after the tick; one sec_tick.
REQ-032 Set 23:59:59 28/02/24 -> 29/02/24 after the tick; set 23:59:59 28/02/23 -> 01/03/23.
REQ-033 Set 23:59:59 30/04/10 -> 01/05/10; set days=31 months=4 -> set_err pulse, fields unchanged.
REQ-034 Assert set_valid with valid data in a tick cycle -> loaded values shown, no increment, next sec_tick 4 cycles later.
REQ-035 Assert rst for one cycle mid-second after setting 12:34:56 -> 00:00:00 01/01/00; next tick 4 cycles after release.
